// File: rtl/jtkunio_gfx_rom_arb_pkg.sv
// jtkunio_gfx_rom_arb_pkg
// Shared definitions for the kunio graphics ROM arbiter:
//   - SDRAM word address width
//   - cache slot identifiers (char, scroll, object)
//   - arbiter FSM state encoding
//   - helper that maps a layer ROM word address into the SDRAM word space
package jtkunio_gfx_rom_arb_pkg;

  localparam int SDRAM_AW = 22;

  localparam logic [1:0] SLOT_CHAR = 2'd0;
  localparam logic [1:0] SLOT_SCR  = 2'd1;
  localparam logic [1:0] SLOT_OBJ  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_WAIT_DOK = 2'd2
  } arb_state_e;

  // Region base plus zero-extended layer address; wraps modulo 2^22.
  function automatic logic [SDRAM_AW-1:0] rom_addr(
    input logic [SDRAM_AW-1:0] offset,
    input logic [17:0]         addr
  );
    return offset + {4'd0, addr};
  endfunction

endpackage

// File: rtl/jtkunio_gfx_rom_arb_if.sv
// jtkunio_gfx_rom_arb_if
// SDRAM read port between the graphics ROM arbiter and the SDRAM controller.
//   sdram_req  : level request, held until sdram_ack
//   sdram_addr : word address, stable while sdram_req is high
//   sdram_ack  : one-cycle pulse, request accepted
//   sdram_dok  : one-cycle pulse, sdram_data valid
//   sdram_data : 32-bit read data
// master = arbiter side, slave = SDRAM controller side.
interface jtkunio_gfx_rom_arb_if;
  import jtkunio_gfx_rom_arb_pkg::*;

  logic                sdram_req;
  logic [SDRAM_AW-1:0] sdram_addr;
  logic                sdram_ack;
  logic                sdram_dok;
  logic [31:0]         sdram_data;

  modport master (
    output sdram_req,
    output sdram_addr,
    input  sdram_ack,
    input  sdram_dok,
    input  sdram_data
  );

  modport slave (
    input  sdram_req,
    input  sdram_addr,
    output sdram_ack,
    output sdram_dok,
    output sdram_data
  );
endinterface

// File: rtl/jtkunio_gfx_rom_arb_slot.sv
// jtkunio_rom_slot
// Single-entry cache for one graphics layer requester.
//   clk, rst  : clock, synchronous active-high reset (clears tag/data/valid)
//   addr      : current requester word address
//   fill      : write strobe from the arbiter
//   fill_tag  : address the fetched word belongs to
//   fill_data : fetched word
//   data      : cached word
//   hit       : entry valid and tag equals the current addr (combinational)
module jtkunio_rom_slot #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          fill,
  input  logic [AW-1:0] fill_tag,
  input  logic [31:0]   fill_data,
  output logic [31:0]   data,
  output logic          hit
);

  logic [AW-1:0] tag_r;
  logic [31:0]   data_r;
  logic          valid_r;

  // Entry storage: cleared by reset, overwritten on each fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_r   <= {AW{1'b0}};
      data_r  <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else if (fill) begin
      tag_r   <= fill_tag;
      data_r  <= fill_data;
      valid_r <= 1'b1;
    end else begin
      tag_r   <= tag_r;
      data_r  <= data_r;
      valid_r <= valid_r;
    end
  end

  // The compare uses the live address so an address change drops the hit at once.
  assign hit  = valid_r && (addr == tag_r);
  assign data = data_r;

endmodule

// File: rtl/jtkunio_gfx_rom_arb.sv
// jtkunio_gfx_rom_arb
// Serves the char, scroll and object graphics layers from one 32-bit SDRAM read
// port. Each layer has a single-entry cache; a miss triggers one SDRAM fetch,
// chosen by fixed priority char > scroll > object.
//   clk, rst              : clock, synchronous active-high reset
//   char_addr/data/ok     : char layer, 14-bit word address
//   scr_addr/data/ok      : scroll layer, 17-bit word address
//   obj_cs/addr/data/ok   : object layer, 18-bit word address, ignored when obj_cs=0
//   sdram                 : SDRAM read port (master modport)
module jtkunio_gfx_rom_arb
  import jtkunio_gfx_rom_arb_pkg::*;
#(
  parameter logic [SDRAM_AW-1:0] CHAR_OFFSET = 22'h00000,
  parameter logic [SDRAM_AW-1:0] SCR_OFFSET  = 22'h04000,
  parameter logic [SDRAM_AW-1:0] OBJ_OFFSET  = 22'h24000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [13:0]           char_addr,
  output logic [31:0]           char_data,
  output logic                  char_ok,
  input  logic [16:0]           scr_addr,
  output logic [31:0]           scr_data,
  output logic                  scr_ok,
  input  logic                  obj_cs,
  input  logic [17:0]           obj_addr,
  output logic [31:0]           obj_data,
  output logic                  obj_ok,
  jtkunio_gfx_rom_arb_if.master sdram
);

  arb_state_e          state_r, state_nx;
  logic [1:0]          sel_r, sel_nx;
  logic [17:0]         lat_addr_r, lat_addr_nx;
  logic                sdram_req_r, req_nx;
  logic [SDRAM_AW-1:0] sdram_addr_r, addr_nx;
  logic                fill_s;
  logic                char_hit_s, scr_hit_s, obj_hit_s;
  logic                char_miss_s, scr_miss_s, obj_miss_s;
  logic                fill_char_s, fill_scr_s, fill_obj_s;

  assign fill_char_s = fill_s && (sel_r == SLOT_CHAR);
  assign fill_scr_s  = fill_s && (sel_r == SLOT_SCR);
  assign fill_obj_s  = fill_s && (sel_r == SLOT_OBJ);

  jtkunio_rom_slot #(.AW(14)) u_char (
    .clk       (clk),
    .rst       (rst),
    .addr      (char_addr),
    .fill      (fill_char_s),
    .fill_tag  (lat_addr_r[13:0]),
    .fill_data (sdram.sdram_data),
    .data      (char_data),
    .hit       (char_hit_s)
  );

  jtkunio_rom_slot #(.AW(17)) u_scr (
    .clk       (clk),
    .rst       (rst),
    .addr      (scr_addr),
    .fill      (fill_scr_s),
    .fill_tag  (lat_addr_r[16:0]),
    .fill_data (sdram.sdram_data),
    .data      (scr_data),
    .hit       (scr_hit_s)
  );

  jtkunio_rom_slot #(.AW(18)) u_obj (
    .clk       (clk),
    .rst       (rst),
    .addr      (obj_addr),
    .fill      (fill_obj_s),
    .fill_tag  (lat_addr_r),
    .fill_data (sdram.sdram_data),
    .data      (obj_data),
    .hit       (obj_hit_s)
  );

  // The object layer neither reports ok nor requests a fetch while deselected.
  assign char_ok     = char_hit_s;
  assign scr_ok      = scr_hit_s;
  assign obj_ok      = obj_cs && obj_hit_s;
  assign char_miss_s = !char_hit_s;
  assign scr_miss_s  = !scr_hit_s;
  assign obj_miss_s  = obj_cs && !obj_hit_s;

  assign sdram.sdram_req  = sdram_req_r;
  assign sdram.sdram_addr = sdram_addr_r;

  // State, latched fetch context and SDRAM port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      sel_r        <= SLOT_CHAR;
      lat_addr_r   <= 18'd0;
      sdram_req_r  <= 1'b0;
      sdram_addr_r <= 22'd0;
    end else begin
      state_r      <= state_nx;
      sel_r        <= sel_nx;
      lat_addr_r   <= lat_addr_nx;
      sdram_req_r  <= req_nx;
      sdram_addr_r <= addr_nx;
    end
  end

  // Next-state logic: pick a miss in IDLE, drop req on ack, fill on dok.
  always_comb begin
    state_nx    = state_r;
    sel_nx      = sel_r;
    lat_addr_nx = lat_addr_r;
    req_nx      = sdram_req_r;
    addr_nx     = sdram_addr_r;
    fill_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (char_miss_s) begin
          sel_nx      = SLOT_CHAR;
          lat_addr_nx = {4'd0, char_addr};
          addr_nx     = rom_addr(CHAR_OFFSET, {4'd0, char_addr});
          req_nx      = 1'b1;
          state_nx    = ST_WAIT_ACK;
        end else if (scr_miss_s) begin
          sel_nx      = SLOT_SCR;
          lat_addr_nx = {1'b0, scr_addr};
          addr_nx     = rom_addr(SCR_OFFSET, {1'b0, scr_addr});
          req_nx      = 1'b1;
          state_nx    = ST_WAIT_ACK;
        end else if (obj_miss_s) begin
          sel_nx      = SLOT_OBJ;
          lat_addr_nx = obj_addr;
          addr_nx     = rom_addr(OBJ_OFFSET, obj_addr);
          req_nx      = 1'b1;
          state_nx    = ST_WAIT_ACK;
        end else begin
          state_nx    = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        // A dok without ack here is stray and ignored; ack+dok together completes.
        if (sdram.sdram_ack) begin
          req_nx = 1'b0;
          if (sdram.sdram_dok) begin
            fill_s   = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_WAIT_DOK;
          end
        end else begin
          state_nx = ST_WAIT_ACK;
        end
      end
      ST_WAIT_DOK: begin
        if (sdram.sdram_dok) begin
          fill_s   = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_WAIT_DOK;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        req_nx   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_jtkunio_gfx_rom_arb.sv
// tb_jtkunio_gfx_rom_arb
// Directed scenarios followed by randomized traffic. A transaction-level model of
// the three caches and the outstanding fetch predicts ok/data and the SDRAM
// request stream; a compare process checks the DUT against it on every cycle.
module tb_jtkunio_gfx_rom_arb;

  localparam logic [21:0] C_OFF = 22'h00000;
  localparam logic [21:0] S_OFF = 22'h04000;
  localparam logic [21:0] O_OFF = 22'h24000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] char_addr = 14'd0;
  logic [16:0] scr_addr  = 17'd0;
  logic        obj_cs    = 1'b0;
  logic [17:0] obj_addr  = 18'd0;
  logic [31:0] char_data, scr_data, obj_data;
  logic        char_ok, scr_ok, obj_ok;

  jtkunio_gfx_rom_arb_if bus();

  jtkunio_gfx_rom_arb #(
    .CHAR_OFFSET(C_OFF), .SCR_OFFSET(S_OFF), .OBJ_OFFSET(O_OFF)
  ) dut (
    .clk(clk), .rst(rst),
    .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
    .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .sdram(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_data  [3];
  logic [17:0] m_tag   [3];
  bit          m_valid [3];
  bit          m_busy  = 1'b0;
  bit          m_acked = 1'b0;
  int          m_slot  = 0;
  logic [17:0] m_faddr = 18'd0;
  bit          m_req   = 1'b0;
  logic [21:0] m_addr  = 22'd0;

  function automatic logic [17:0] cur_addr(input int s);
    if (s == 0) return {4'd0, char_addr};
    else if (s == 1) return {1'b0, scr_addr};
    else return obj_addr;
  endfunction

  function automatic logic [21:0] region(input int s);
    if (s == 0) return C_OFF;
    else if (s == 1) return S_OFF;
    else return O_OFF;
  endfunction

  function automatic bit wanted(input int s);
    return (s != 2) || obj_cs;
  endfunction

  function automatic bit cached(input int s);
    return m_valid[s] && (m_tag[s] == cur_addr(s));
  endfunction

  function automatic bit exp_ok(input int s);
    return wanted(s) && cached(s);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_valid[i] = 1'b0; m_data[i] = 32'd0; m_tag[i] = 18'd0;
      end
      m_busy = 1'b0; m_acked = 1'b0; m_req = 1'b0; m_addr = 22'd0;
    end else if (!m_busy) begin
      for (int s = 0; s < 3; s++) begin
        if (!m_busy && wanted(s) && !cached(s)) begin
          m_busy  = 1'b1;
          m_acked = 1'b0;
          m_slot  = s;
          m_faddr = cur_addr(s);
          m_req   = 1'b1;
          m_addr  = region(s) + {4'd0, cur_addr(s)};
        end
      end
    end else if (!m_acked ? bus.sdram_ack : bus.sdram_dok) begin
      m_req = 1'b0;
      if (m_acked || bus.sdram_dok) begin
        m_valid[m_slot] = 1'b1;
        m_tag[m_slot]   = m_faddr;
        m_data[m_slot]  = bus.sdram_data;
        m_busy          = 1'b0;
      end else begin
        m_acked = 1'b1;
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("sdram_req", 32'(bus.sdram_req), 32'(m_req));
      if (m_req) chk("sdram_addr", 32'(bus.sdram_addr), 32'(m_addr));
      chk("char_ok", 32'(char_ok), 32'(exp_ok(0)));
      if (exp_ok(0)) chk("char_data", char_data, m_data[0]);
      chk("scr_ok", 32'(scr_ok), 32'(exp_ok(1)));
      if (exp_ok(1)) chk("scr_data", scr_data, m_data[1]);
      chk("obj_ok", 32'(obj_ok), 32'(exp_ok(2)));
      if (exp_ok(2)) chk("obj_data", obj_data, m_data[2]);
    end
  end

  // ---------------- SDRAM responder and stimulus helpers ----------------
  int          rs = 0;
  int          cnt = 0;
  int          ack_dly = 2;
  int          dok_dly = 3;
  bit          resp_en = 1'b1;
  bit          stray_en = 1'b0;
  logic [31:0] next_data = 32'd0;
  logic [21:0] req_log[$];
  bit          req_q = 1'b0;
  int          char_low = 0;

  initial begin
    bus.sdram_ack  = 1'b0;
    bus.sdram_dok  = 1'b0;
    bus.sdram_data = 32'd0;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.sdram_req === 1'b1 && !req_q) req_log.push_back(bus.sdram_addr);
    req_q = (bus.sdram_req === 1'b1);
    if (char_ok !== 1'b1) char_low++;
    bus.sdram_ack  = 1'b0;
    bus.sdram_dok  = 1'b0;
    bus.sdram_data = $urandom;
    if (resp_en) begin
      if (rs == 0) begin
        if (bus.sdram_req === 1'b1) begin
          rs = 1; cnt = ack_dly;
        end else if (stray_en && $urandom_range(0, 15) == 0) begin
          bus.sdram_dok = 1'b1;
        end
      end else if (rs == 1) begin
        if (cnt <= 1) begin
          bus.sdram_ack = 1'b1;
          if (dok_dly == 0) begin
            bus.sdram_dok = 1'b1; bus.sdram_data = next_data; rs = 0;
          end else begin
            rs = 2; cnt = dok_dly;
          end
        end else begin
          cnt--;
          if (stray_en && $urandom_range(0, 7) == 0) bus.sdram_dok = 1'b1;
        end
      end else begin
        if (cnt <= 1) begin
          bus.sdram_dok = 1'b1; bus.sdram_data = next_data; rs = 0;
        end else begin
          cnt--;
        end
      end
    end
  endtask

  task automatic wait_req(input string nm);
    for (int n = 0; n < 100 && bus.sdram_req !== 1'b1; n++) step();
    chk(nm, 32'(bus.sdram_req), 32'd1);
  endtask

  task automatic wait_ack(input string nm);
    for (int n = 0; n < 100 && bus.sdram_ack !== 1'b1; n++) step();
    chk(nm, 32'(bus.sdram_ack), 32'd1);
  endtask

  task automatic wait_dok(input string nm);
    for (int n = 0; n < 100 && bus.sdram_dok !== 1'b1; n++) step();
    chk(nm, 32'(bus.sdram_dok), 32'd1);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    next_data = 32'hDEAD_BEEF;
    step(); step();
    chk("rst_req", 32'(bus.sdram_req), 32'd0);
    chk("rst_addr", 32'(bus.sdram_addr), 32'd0);
    chk("rst_char_ok", 32'(char_ok), 32'd0);
    chk("rst_scr_ok", 32'(scr_ok), 32'd0);
    chk("rst_obj_ok", 32'(obj_ok), 32'd0);
    chk_en = 1'b1;

    // First char fetch and ok latency.
    char_addr = 14'h0123;
    rst = 1'b0;
    wait_req("a_req");
    chk("a_addr", 32'(bus.sdram_addr), 32'h0000_0123);
    wait_dok("a_dok");
    chk("a_ok_at_dok", 32'(char_ok), 32'd0);
    step();
    chk("a_ok", 32'(char_ok), 32'd1);
    chk("a_data", char_data, 32'hDEAD_BEEF);
    next_data = 32'h1357_9BDF;
    repeat (30) step();

    // Three simultaneous misses served in priority order.
    req_log.delete();
    char_addr = 14'h0456; scr_addr = 17'h1_0000; obj_cs = 1'b1; obj_addr = 18'h3_FFFF;
    repeat (40) step();
    chk("b_count", 32'(req_log.size()), 32'd3);
    if (req_log.size() >= 3) begin
      chk("b_first", 32'(req_log[0]), 32'h0000_0456);
      chk("b_second", 32'(req_log[1]), 32'h0001_4000);
      chk("b_third", 32'(req_log[2]), 32'h0006_3FFF);
    end

    // Deselected object requester issues nothing until obj_cs rises.
    req_log.delete();
    obj_cs = 1'b0; obj_addr = 18'h0_0055;
    repeat (50) step();
    chk("c_no_req", 32'(req_log.size()), 32'd0);
    chk("c_obj_ok", 32'(obj_ok), 32'd0);
    obj_cs = 1'b1;
    repeat (12) step();
    chk("c_count", 32'(req_log.size()), 32'd1);
    if (req_log.size() >= 1) chk("c_addr", 32'(req_log[0]), 32'h0002_4055);
    chk("c_obj_ok_after", 32'(obj_ok), 32'd1);

    // Held address keeps hitting; an address change drops ok at once.
    req_log.delete();
    char_low = 0;
    repeat (100) step();
    chk("d_char_low", 32'(char_low), 32'd0);
    chk("d_no_req", 32'(req_log.size()), 32'd0);
    char_addr = 14'h0457;
    #1;
    chk("d_drop", 32'(char_ok), 32'd0);
    repeat (30) step();

    // Scroll address changes while the fetch waits for dok.
    scr_addr = 17'h0_0AAA;
    wait_req("e_req1");
    chk("e_addr1", 32'(bus.sdram_addr), 32'h0000_4AAA);
    wait_ack("e_ack1");
    step();
    scr_addr = 17'h0_0BBB;
    wait_dok("e_dok1");
    step();
    chk("e_ok_stale", 32'(scr_ok), 32'd0);
    wait_req("e_req2");
    chk("e_addr2", 32'(bus.sdram_addr), 32'h0000_4BBB);
    wait_dok("e_dok2");
    step();
    chk("e_ok", 32'(scr_ok), 32'd1);
    repeat (20) step();

    // Reset while waiting for dok, then a late dok.
    char_addr = 14'h0777;
    wait_req("f_req");
    wait_ack("f_ack");
    step();
    rst = 1'b1; resp_en = 1'b0; rs = 0;
    step();
    chk("f_req_off", 32'(bus.sdram_req), 32'd0);
    chk("f_char_ok", 32'(char_ok), 32'd0);
    chk("f_scr_ok", 32'(scr_ok), 32'd0);
    chk("f_obj_ok", 32'(obj_ok), 32'd0);
    rst = 1'b0;
    bus.sdram_dok = 1'b1; bus.sdram_data = 32'h1234_5678;
    step();
    chk("f_no_write", 32'(char_ok), 32'd0);
    resp_en = 1'b1;
    repeat (40) step();

    // ack and dok in the same cycle.
    dok_dly = 0;
    next_data = 32'hCAFE_F00D;
    char_addr = 14'h0999;
    wait_req("g_req");
    wait_ack("g_ack");
    chk("g_dok_with_ack", 32'(bus.sdram_dok), 32'd1);
    chk("g_ok_at_dok", 32'(char_ok), 32'd0);
    step();
    chk("g_ok", 32'(char_ok), 32'd1);
    chk("g_data", char_data, 32'hCAFE_F00D);

    // Randomized traffic against the model.
    stray_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      next_data = $urandom;
      if (rs == 0) begin
        ack_dly = $urandom_range(1, 4);
        dok_dly = $urandom_range(0, 4);
      end
      if ($urandom_range(0, 7) == 0) char_addr = 14'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) scr_addr = 17'h1_FFFC + 17'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) obj_cs = ~obj_cs;
      if ($urandom_range(0, 7) == 0) obj_addr = 18'h2_0000 + 18'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1; resp_en = 1'b0; rs = 0;
        step();
        rst = 1'b0; resp_en = 1'b1;
      end
      step();
    end
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
